// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// FSM states, special-case results and operand signedness helpers.
package muldiv_pkg;

   localparam logic [2:0] SEL_MUL    = 3'b000;
   localparam logic [2:0] SEL_MULH   = 3'b001;
   localparam logic [2:0] SEL_MULHSU = 3'b010;
   localparam logic [2:0] SEL_MULHU  = 3'b011;
   localparam logic [2:0] SEL_DIV    = 3'b100;
   localparam logic [2:0] SEL_DIVU   = 3'b101;
   localparam logic [2:0] SEL_REM    = 3'b110;
   localparam logic [2:0] SEL_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Sized for the widest XLEN; the unit slices the low XLEN bits.
   localparam int              XLEN_MAX  = 64;
   localparam logic [XLEN_MAX-1:0] DIVZ_QUOT = '1;
   localparam logic [XLEN_MAX-1:0] OVF_REM   = '0;

   function automatic logic op_signed1(input logic [2:0] sel);
      return (sel == SEL_MULH) || (sel == SEL_MULHSU) ||
             (sel == SEL_DIV)  || (sel == SEL_REM);
   endfunction

   function automatic logic op_signed2(input logic [2:0] sel);
      return (sel == SEL_MULH) || (sel == SEL_DIV) || (sel == SEL_REM);
   endfunction

   function automatic logic op_is_rem(input logic [2:0] sel);
      return (sel == SEL_REM) || (sel == SEL_REMU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add, right shift of
// the {hi,lo} product) and divide (restoring shift-subtract, left shift).
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            mode_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0]   add_a;
   logic [XLEN:0]   add_b;
   logic [XLEN+1:0] sum;
   logic            no_borrow;

   always_comb begin
      if (mode_div) begin
         add_a = {hi, lo[XLEN-1]};
         add_b = ~{1'b0, opnd};
      end else begin
         add_a = {1'b0, hi};
         add_b = {1'b0, opnd};
      end
      sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, mode_div};
      // Carry out of the subtract means shifted remainder >= divisor.
      no_borrow = sum[XLEN+1];

      if (mode_div) begin
         hi_nxt = no_borrow ? sum[XLEN-1:0] : add_a[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], no_borrow};
      end else if (lo[0]) begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end else begin
         hi_nxt = {1'b0, hi[XLEN-1:1]};
         lo_nxt = {hi[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit: magnitudes iterate for XLEN
// cycles, signs are restored in a single fix-up cycle.
//
//   state | meaning
//   IDLE  | waiting for START
//   CALC  | XLEN radix-2 iterations on operand magnitudes
//   FIX   | sign correction / result select, RESULT loaded
//   DONE  | VALID pulse, new START accepted
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic            KILL,
   input  logic [2:0]      SELECT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic            BUSY,
   output logic            VALID,
   output logic [XLEN-1:0] RESULT
);

   localparam int              CW       = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   hi, lo, opnd;
   logic [XLEN-1:0]   hi_nxt, lo_nxt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   result_q;

   logic              busy, accept, sgn1, sgn2, div_zero, div_ovf;
   logic [XLEN-1:0]   mag1, mag2, word, word_fix, result_d;
   logic [2*XLEN-1:0] prod;

   assign busy     = (state == ST_CALC) || (state == ST_FIX);
   assign accept   = START && !busy && !KILL;
   assign sgn1     = op_signed1(SELECT) && DATA1[XLEN-1];
   assign sgn2     = op_signed2(SELECT) && DATA2[XLEN-1];
   assign mag1     = sgn1 ? -DATA1 : DATA1;
   assign mag2     = sgn2 ? -DATA2 : DATA2;
   assign div_zero = SELECT[2] && (DATA2 == '0);
   assign div_ovf  = SELECT[2] && !SELECT[0] && (DATA1 == MOST_NEG) && (DATA2 == '1);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode_div (op_q[2]),
      .hi       (hi),
      .lo       (lo),
      .opnd     (opnd),
      .hi_nxt   (hi_nxt),
      .lo_nxt   (lo_nxt)
   );

   // Divide keeps the remainder in hi and the quotient in lo.
   always_comb begin
      prod     = neg_q ? -{hi, lo} : {hi, lo};
      word     = op_is_rem(op_q) ? hi : lo;
      word_fix = neg_q ? -word : word;
      result_d = word_fix;
      if (!op_q[2]) begin
         result_d = (op_q == SEL_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (KILL) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  op_q <= SELECT;
                  cnt  <= '0;
                  if (div_zero) begin
                     hi    <= DATA1;
                     lo    <= DIVZ_QUOT[XLEN-1:0];
                     neg_q <= 1'b0;
                     state <= ST_FIX;
                  end else if (div_ovf) begin
                     hi    <= OVF_REM[XLEN-1:0];
                     lo    <= DATA1;
                     neg_q <= 1'b0;
                     state <= ST_FIX;
                  end else if (SELECT[2]) begin
                     hi    <= '0;
                     lo    <= mag1;
                     opnd  <= mag2;
                     neg_q <= op_is_rem(SELECT) ? sgn1 : (sgn1 ^ sgn2);
                     state <= ST_CALC;
                  end else begin
                     hi    <= '0;
                     lo    <= mag2;
                     opnd  <= mag1;
                     neg_q <= sgn1 ^ sgn2;
                     state <= ST_CALC;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               result_q <= result_d;
               state    <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign BUSY   = busy;
   assign VALID  = (state == ST_DONE);
   assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table,
// interference/kill/reset sequences and randomized ops against a model.
module tb_muldiv_unit;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 2;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        START = 1'b0;
   logic        KILL = 1'b0;
   logic [2:0]  SELECT = 3'd0;
   logic [31:0] DATA1 = 32'd0;
   logic [31:0] DATA2 = 32'd0;
   logic        BUSY;
   logic        VALID;
   logic [31:0] RESULT;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] last_res = 32'd0;

   always #5 CLK = ~CLK;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .START   (START),
      .KILL    (KILL),
      .SELECT  (SELECT),
      .DATA1   (DATA1),
      .DATA2   (DATA2),
      .BUSY    (BUSY),
      .VALID   (VALID),
      .RESULT  (RESULT)
   );

   typedef struct {
      string       name;
      logic [2:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain 64-bit arithmetic on the architectural op definitions.
   function automatic logic [31:0] ref_res(input logic [2:0] sel, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ub = longint'({32'd0, b});
      logic [63:0] p;
      case (sel)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4, 3'd6: begin
            if (b == 32'd0) return (sel == 3'd4) ? 32'hFFFF_FFFF : a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (sel == 3'd4) ? a : 32'd0;
            return (sel == 3'd4) ? 32'(sa / sb) : 32'(sa % sb);
         end
         default: begin
            if (b == 32'd0) return (sel == 3'd5) ? 32'hFFFF_FFFF : a;
            return (sel == 3'd5) ? (a / b) : (a % b);
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
      if (sel[2] && (b == 32'd0)) return 2;
      if ((sel == 3'd4 || sel == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return LAT;
   endfunction

   // Call right after a negedge; the following posedge is the accept edge.
   task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input int junk_at, input int kill_at);
      int busy_err = 0;
      int valid_cnt = 0;
      int valid_at = -1;
      bit eb;
      START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
      for (int k = 1; k <= lat; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            START = 1'b0; SELECT = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
         end
         eb = (k < lat) && (kill_at < 0 || k <= kill_at);
         if (BUSY !== eb) busy_err++;
         if (VALID === 1'b1) begin valid_cnt++; valid_at = k; end
         if (k == lat) check({name, " result"}, 64'(RESULT), 64'((kill_at < 0) ? exp : last_res));
         if (k == junk_at) begin
            START = 1'b1; SELECT = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
         end
         if (k == junk_at + 1) START = 1'b0;
         if (k == kill_at) KILL = 1'b1;
         if (k == kill_at + 1) KILL = 1'b0;
      end
      check({name, " valid cycle"}, 64'(valid_at), 64'((kill_at < 0) ? lat : -1));
      check({name, " valid count"}, 64'(valid_cnt), 64'((kill_at < 0) ? 1 : 0));
      check({name, " busy errors"}, 64'(busy_err), 64'd0);
      if (kill_at < 0) last_res = exp;
   endtask

   vec_t tbl[14];

   initial begin
      int stray;
      logic [2:0]  rs;
      logic [31:0] ra, rb;

      tbl[0]  = '{"mul_neg",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
      tbl[1]  = '{"mulh_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT};
      tbl[2]  = '{"mulhu_ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
      tbl[3]  = '{"mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT};
      tbl[4]  = '{"div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT};
      tbl[5]  = '{"rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT};
      tbl[6]  = '{"divu_100_7",  3'd5, 32'd100,       32'd7,         32'd14,        LAT};
      tbl[7]  = '{"remu_100_7",  3'd7, 32'd100,       32'd7,         32'd2,         LAT};
      tbl[8]  = '{"divu_by0",    3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
      tbl[9]  = '{"remu_by0",    3'd7, 32'd5,         32'd0,         32'd5,         2};
      tbl[10] = '{"div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
      tbl[11] = '{"rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2};
      tbl[12] = '{"rem_by0_neg", 3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2};
      tbl[13] = '{"mul_zero",    3'd0, 32'd0,         32'h1234_5678, 32'd0,         LAT};

      repeat (3) @(negedge CLK);
      check("reset busy", 64'(BUSY), 64'd0);
      check("reset valid", 64'(VALID), 64'd0);
      check("reset result", 64'(RESULT), 64'd0);
      RESET_N = 1'b1;
      @(negedge CLK);

      foreach (tbl[i]) run_op(tbl[i].name, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, -1, -1);

      // START while busy must be ignored; then a killed op leaves RESULT alone.
      run_op("mul_3x4_junk", 3'd0, 32'd3, 32'd4, 32'd12, LAT, 10, -1);
      run_op("mul_kill", 3'd0, 32'd5, 32'd6, 32'd30, LAT, -1, 15);

      // Asynchronous reset in the middle of a divide.
      @(negedge CLK);
      START = 1'b1; SELECT = 3'd5; DATA1 = 32'd100; DATA2 = 32'd7;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         if (k == 1) START = 1'b0;
      end
      RESET_N = 1'b0;
      #1;
      check("midreset busy", 64'(BUSY), 64'd0);
      check("midreset valid", 64'(VALID), 64'd0);
      check("midreset result", 64'(RESULT), 64'd0);
      last_res = 32'd0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (VALID !== 1'b0 || BUSY !== 1'b0) stray++;
      end
      check("post-reset quiet", 64'(stray), 64'd0);
      run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, LAT, -1, -1);

      // Randomized, issued back-to-back (each START lands in the previous DONE).
      for (int i = 0; i < 40; i++) begin
         rs = 3'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: ;
         endcase
         run_op($sformatf("rnd%0d_sel%0d", i, rs), rs, ra, rb, ref_res(rs, ra, rb),
                ref_lat(rs, ra, rb), -1, -1);
      end

      @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
